// File: rtl/token_fifo0.sv
// Zero-width token FIFO: occupancy count, registered full/empty flags, sticky error.
// Optional macro TOKEN_FIFO0_BYPASS_EN lets ENQ pass straight to DEQ when empty.
module token_fifo0 #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          ENQ,
  output logic          FULL_N,
  input  logic          DEQ,
  output logic          EMPTY_N,
  input  logic          CLR,
  output logic [CW-1:0] COUNT,
  output logic          ERR
);

  localparam logic [CW-1:0] LP_DEPTH = CW'(DEPTH);
  localparam logic [CW-1:0] LP_ONE   = CW'(1);

  logic [CW-1:0] r_count;
  logic          r_full_n;
  logic          r_empty_n;
  logic          r_err;

  logic [CW-1:0] w_next;
  logic          w_enq_ok;
  logic          w_deq_ok;
  logic          w_viol;

  assign w_enq_ok = ENQ & r_full_n;

`ifdef TOKEN_FIFO0_BYPASS_EN
  // An enqueue on an empty FIFO can feed a same-cycle dequeue.
  assign w_deq_ok = DEQ & (r_empty_n | ENQ);
  assign EMPTY_N  = r_empty_n | ENQ;
`else
  assign w_deq_ok = DEQ & r_empty_n;
  assign EMPTY_N  = r_empty_n;
`endif

  assign w_viol = (ENQ & ~r_full_n) | (DEQ & ~w_deq_ok);

  // Arithmetic only on legal ops, so the count cannot wrap.
  always_comb begin
    w_next = r_count;
    if (CLR) begin
      w_next = '0;
    end else if (w_enq_ok && !w_deq_ok) begin
      w_next = r_count + LP_ONE;
    end else if (w_deq_ok && !w_enq_ok) begin
      w_next = r_count - LP_ONE;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_count   <= '0;
      r_full_n  <= 1'b1;
      r_empty_n <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_count   <= w_next;
      r_full_n  <= (w_next != LP_DEPTH);
      r_empty_n <= (w_next != '0);
      if (CLR) begin
        r_err <= 1'b0;
      end else if (w_viol) begin
        r_err <= 1'b1;
      end
    end
  end

  assign FULL_N = r_full_n;
  assign COUNT  = r_count;
  assign ERR    = r_err;

endmodule

// File: tb/tb_token_fifo0.sv
// Directed bench for token_fifo0 (DEPTH=4, CW=3).
// Expectations follow TOKEN_FIFO0_BYPASS_EN when it is defined.
module tb_token_fifo0;

  logic       CLK;
  logic       RST_N;
  logic       ENQ;
  logic       DEQ;
  logic       CLR;
  logic       FULL_N;
  logic       EMPTY_N;
  logic [2:0] COUNT;
  logic       ERR;

  int n_cmp;
  int n_bad;

  token_fifo0 #(.DEPTH(4), .CW(3)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .ENQ    (ENQ),
    .FULL_N (FULL_N),
    .DEQ    (DEQ),
    .EMPTY_N(EMPTY_N),
    .CLR    (CLR),
    .COUNT  (COUNT),
    .ERR    (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic e, input logic d, input logic c);
    ENQ = e;
    DEQ = d;
    CLR = c;
    @(posedge CLK);
    #1;
    ENQ = 1'b0;
    DEQ = 1'b0;
    CLR = 1'b0;
  endtask

  task automatic chk_all(input string tag, input logic [2:0] c,
                         input logic f, input logic e, input logic r);
    chk({tag, ".count"}, 32'(COUNT), 32'(c));
    chk({tag, ".full_n"}, 32'(FULL_N), 32'(f));
    chk({tag, ".empty_n"}, 32'(EMPTY_N), 32'(e));
    chk({tag, ".err"}, 32'(ERR), 32'(r));
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    ENQ   = 1'b0;
    DEQ   = 1'b0;
    CLR   = 1'b0;
    RST_N = 1'b1;
    #2 RST_N = 1'b0;
    #1 chk_all("rst0", 3'd0, 1'b1, 1'b0, 1'b0);
    #3 RST_N = 1'b1;
    @(posedge CLK);
    #1;

    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("pre_rst.count", 32'(COUNT), 32'(i));
    end
    RST_N = 1'b0;
    #1 chk_all("rst_mid", 3'd0, 1'b1, 1'b0, 1'b0);
    #1 RST_N = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk_all("rst_idle", 3'd0, 1'b1, 1'b0, 1'b0);

    for (int i = 1; i <= 4; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk("fill.count", 32'(COUNT), 32'(i));
    end
    chk_all("full", 3'd4, 1'b0, 1'b1, 1'b0);
    for (int i = 3; i >= 0; i--) begin
      step(1'b0, 1'b1, 1'b0);
      chk("drain.count", 32'(COUNT), 32'(i));
    end
    chk_all("drained", 3'd0, 1'b1, 1'b0, 1'b0);

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_all("stream", 3'd2, 1'b1, 1'b1, 1'b0);
    end

    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_all("full2", 3'd4, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("ovf", 3'd3, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0);
    chk_all("ovf_hold", 3'd3, 1'b1, 1'b1, 1'b1);

    step(1'b1, 1'b1, 1'b1);
    chk_all("clr_pri", 3'd0, 1'b1, 1'b0, 1'b0);

    step(1'b0, 1'b1, 1'b0);
    chk_all("udf", 3'd0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk_all("clr", 3'd0, 1'b1, 1'b0, 1'b0);

    ENQ = 1'b1;
    DEQ = 1'b1;
    #1;
`ifdef TOKEN_FIFO0_BYPASS_EN
    chk("simul.empty_n_comb", 32'(EMPTY_N), 32'd1);
    step(1'b1, 1'b1, 1'b0);
    chk_all("simul", 3'd0, 1'b1, 1'b0, 1'b0);
`else
    chk("simul.empty_n_comb", 32'(EMPTY_N), 32'd0);
    step(1'b1, 1'b1, 1'b0);
    chk_all("simul", 3'd1, 1'b1, 1'b1, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/token_fifo0.md
Name: token_fifo0

Overview:
- Zero-data-width token FIFO. Counts occupancy events so a producer and consumer can hand off "something happened" tokens with full/empty flow control.
- Sits directly downstream of a zero-width wire: the wire's WHAS output drives ENQ, and the consumer rule drives DEQ.
- Stores no data; only a saturating-checked occupancy count, registered status flags and a sticky error.

Parameters:
- DEPTH, 4, maximum number of tokens held; legal range 1..2^CW-1.
- CW, 3, width of the occupancy counter and COUNT port; must satisfy 2^CW > DEPTH.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST_N  input  1  asynchronous active-low reset.
- ENQ  input  1  enqueue one token this cycle.
- FULL_N  output  1  registered; 1 = space available (count < DEPTH).
- DEQ  input  1  dequeue one token this cycle.
- EMPTY_N  output  1  registered, except as noted under Optional Feature; 1 = at least one token held (count > 0).
- CLR  input  1  synchronous clear of occupancy and error.
- COUNT  output  CW  current occupancy, registered.
- ERR  output  1  sticky protocol-violation flag, registered.

Behaviour:
- Reset (RST_N low, asynchronous, any time including mid-operation):
  - count=0, COUNT=0, EMPTY_N=0, FULL_N=1, ERR=0.
  - Outputs take these values immediately on reset assertion, without waiting for a clock edge.
  - Normal operation resumes on the first rising CLK edge after RST_N deasserts.
- Legal operations, evaluated against the registered flags at the current edge:
  - enq_ok = ENQ & FULL_N.
  - deq_ok = DEQ & EMPTY_N (bypass case under Optional Feature).
- Next count:
  - CLR=1 → 0. CLR has priority over ENQ/DEQ; ERR is cleared the same cycle.
  - enq_ok & !deq_ok → count+1.
  - deq_ok & !enq_ok → count-1.
  - Both ok → unchanged.
  - Neither → unchanged.
- Flags are registered from next count:
  - FULL_N_next = (next_count != DEPTH).
  - EMPTY_N_next = (next_count != 0).
  - Latency is 1 cycle: a token enqueued at edge N is visible on EMPTY_N/COUNT after edge N.
- Count never wraps: arithmetic is only performed when the corresponding op is legal.
- Full boundary: ENQ while FULL_N=0 is ignored, even if DEQ is asserted the same cycle. No pipelined enq-on-full. Sets ERR. DEQ still proceeds.
- Empty boundary: DEQ while EMPTY_N=0 (and no bypass) is ignored and sets ERR. ENQ still proceeds.
- ERR:
  - set when (ENQ & !FULL_N) | (DEQ & !deq_ok) and CLR=0.
  - held until CLR or reset.
  - CLR in the same cycle as a violation: CLR wins, ERR=0.
- DEPTH=1: behaves as a single-token flag register; simultaneous ENQ/DEQ while full → ENQ error, DEQ accepted, count=0.
- No combinational path from inputs to outputs except under Optional Feature.

Optional Feature:
- Macro: TOKEN_FIFO0_BYPASS_EN.
- Defined:
  - EMPTY_N = empty_n_reg | ENQ (combinational path ENQ→EMPTY_N).
  - When count==0 and ENQ & DEQ in the same cycle, both are legal, the token passes through, and count stays 0 with no ERR.
  - When count>0, behaviour is identical to the undefined case.
- Undefined:
  - EMPTY_N is purely registered.
  - ENQ & DEQ on empty → enqueue accepted, dequeue is an error: count=1, ERR=1.

Test Plan:
- Reset: assert RST_N=0 mid-stream with count=3 → COUNT=0, EMPTY_N=0, FULL_N=1, ERR=0 with no clock edge needed. Release, idle 2 cycles → values unchanged.
- Fill/drain, DEPTH=4: 4 cycles ENQ=1 → COUNT 1,2,3,4, FULL_N=0 after 4th edge. 4 cycles DEQ=1 → COUNT 3,2,1,0, EMPTY_N=0 after last edge. ERR stays 0.
- Overflow: at COUNT=4 assert ENQ=1, DEQ=1 → COUNT=3, ERR=1. Then 3 idle cycles → ERR remains 1.
- Steady stream: at COUNT=2 assert ENQ=DEQ=1 for 10 cycles → COUNT=2 throughout, FULL_N=1, EMPTY_N=1, ERR=0.
- Clear priority: COUNT=3, ERR=1, CLR=ENQ=DEQ=1 → next COUNT=0, EMPTY_N=0, FULL_N=1, ERR=0.
- Empty simultaneous: COUNT=0, ENQ=DEQ=1 one cycle.
  - Macro defined → EMPTY_N=1 during that cycle, then COUNT=0, ERR=0.
  - Macro undefined → EMPTY_N=0 during that cycle, then COUNT=1, ERR=1.
